// File: rtl/sextium_pkg.sv
// Shared constants, state encoding and power-of-ten helper for the Sextium III syscall unit.
package sextium_pkg;

    localparam int unsigned SYS_HALT  = 0;
    localparam int unsigned SYS_READ  = 1;
    localparam int unsigned SYS_WRITE = 2;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_NL    = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_RD,
        ST_WR_SIGN,
        ST_WR_DIG,
        ST_WR_EMIT,
        ST_WR_NL,
        ST_FINISH,
        ST_HALT
    } state_t;

    // 10^k for k in 0..9; larger k saturates at 10^9.
    function automatic logic [63:0] pow10(input int unsigned k);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < k) begin
                p = p * 64'd10;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/dec_digit_gen.sv
// Extracts one decimal digit of mag at position k by repeated subtraction of 10^k.
module dec_digit_gen
    import sextium_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mag,
    input  logic [KW-1:0]    k,
    output logic [3:0]       digit,
    output logic             done,
    output logic [WIDTH-1:0] rest
);

    logic             busy;
    logic [WIDTH-1:0] pow;

    assign pow = WIDTH'(pow10(32'(k)));

    // One subtraction per cycle; done pulses once the remainder drops below 10^k.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            digit <= 4'd0;
            rest  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rest  <= mag;
                digit <= 4'd0;
                busy  <= 1'b1;
            end else if (busy) begin
                if (rest >= pow) begin
                    rest  <= rest - pow;
                    digit <= digit + 4'd1;
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL service unit: HALT, READ (parse decimal from rx) and WRITE (print DR to tx).
module syscall_unit
    import sextium_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             runio,
    input  logic [WIDTH-1:0] code_in,
    input  logic [WIDTH-1:0] dr_in,
    output logic             iobusy,
    output logic [WIDTH-1:0] io_out,
    output logic             halted,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int unsigned   KW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(DIGITS - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] code, dr, mag, acc;
    logic             neg, seen_digit, lead;
    logic [KW-1:0]    k;

    logic             gen_start, gen_done;
    logic [3:0]       gen_digit;
    logic [WIDTH-1:0] gen_rest;

    logic             tx_valid_nxt, rx_ready_nxt, halted_nxt;
    logic [7:0]       tx_data_nxt;
    logic [WIDTH-1:0] io_out_nxt;

    logic rx_fire, tx_fire, dr_neg, rx_is_digit, rx_is_nl, emit_digit;

    assign rx_fire     = rx_valid && rx_ready;
    assign tx_fire     = tx_valid && tx_ready;
    assign dr_neg      = dr[WIDTH-1];
    assign rx_is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
    assign rx_is_nl    = (rx_data == CH_NL);
    // A digit prints once a nonzero digit has appeared, or always at the units place.
    assign emit_digit  = (gen_digit != 4'd0) || !lead || (k == '0);
    assign iobusy      = runio && (state != ST_FINISH);

    dec_digit_gen #(.WIDTH(WIDTH), .KW(KW)) u_digit (
        .clock (clock),
        .reset (reset),
        .start (gen_start),
        .mag   (mag),
        .k     (k),
        .digit (gen_digit),
        .done  (gen_done),
        .rest  (gen_rest)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and digit-extractor kick-off.
    always_comb begin
        state_nxt = state;
        gen_start = 1'b0;
        case (state)
            ST_IDLE:     if (runio) state_nxt = ST_DISPATCH;
            ST_DISPATCH: begin
                if      (code == WIDTH'(SYS_HALT))  state_nxt = ST_HALT;
                else if (code == WIDTH'(SYS_READ))  state_nxt = ST_RD;
                else if (code == WIDTH'(SYS_WRITE)) state_nxt = ST_WR_SIGN;
                else                                state_nxt = ST_FINISH;
            end
            ST_RD:       if (rx_fire && rx_is_nl) state_nxt = ST_FINISH;
            ST_WR_SIGN: begin
                if (!dr_neg || tx_fire) begin
                    state_nxt = ST_WR_DIG;
                    gen_start = 1'b1;
                end
            end
            ST_WR_DIG: begin
                if (gen_done) begin
                    if (emit_digit) state_nxt = ST_WR_EMIT;
                    else            gen_start = 1'b1;
                end
            end
            ST_WR_EMIT: begin
                if (tx_fire) begin
                    if (k == '0) begin
                        state_nxt = ST_WR_NL;
                    end else begin
                        state_nxt = ST_WR_DIG;
                        gen_start = 1'b1;
                    end
                end
            end
            ST_WR_NL:    if (tx_fire) state_nxt = ST_FINISH;
            ST_FINISH:   if (!runio) state_nxt = ST_IDLE;
            ST_HALT:     state_nxt = ST_HALT;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        rx_ready_nxt = (state_nxt == ST_RD);
        io_out_nxt   = io_out;
        halted_nxt   = halted || (state_nxt == ST_HALT);
        case (state_nxt)
            ST_WR_SIGN: begin
                if (dr_neg) begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = CH_MINUS;
                end
            end
            ST_WR_EMIT: begin
                tx_valid_nxt = 1'b1;
                if (state == ST_WR_DIG) tx_data_nxt = CH_0 + {4'b0000, gen_digit};
            end
            ST_WR_NL: begin
                tx_valid_nxt = 1'b1;
                tx_data_nxt  = CH_NL;
            end
            default: ;
        endcase
        if (state == ST_RD && rx_fire && rx_is_nl) begin
            io_out_nxt = neg ? -acc : acc;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            rx_ready <= 1'b0;
            io_out   <= '0;
            halted   <= 1'b0;
        end else begin
            tx_valid <= tx_valid_nxt;
            tx_data  <= tx_data_nxt;
            rx_ready <= rx_ready_nxt;
            io_out   <= io_out_nxt;
            halted   <= halted_nxt;
        end
    end

    // Operand latch, READ accumulator and WRITE digit position.
    always_ff @(posedge clock) begin
        if (!reset) begin
            code       <= '0;
            dr         <= '0;
            mag        <= '0;
            acc        <= '0;
            neg        <= 1'b0;
            seen_digit <= 1'b0;
            lead       <= 1'b0;
            k          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (runio) begin
                        code <= code_in;
                        dr   <= dr_in;
                    end
                end
                ST_DISPATCH: begin
                    acc        <= '0;
                    neg        <= 1'b0;
                    seen_digit <= 1'b0;
                    mag        <= dr_neg ? -dr : dr;
                    lead       <= 1'b1;
                    k          <= K_TOP;
                end
                ST_RD: begin
                    if (rx_fire) begin
                        if (rx_is_digit) begin
                            acc        <= (acc << 3) + (acc << 1) + WIDTH'(rx_data - CH_0);
                            seen_digit <= 1'b1;
                        end else if (rx_data == CH_MINUS && !seen_digit) begin
                            neg <= 1'b1;
                        end
                    end
                end
                ST_WR_DIG: begin
                    if (gen_done) begin
                        if (emit_digit) begin
                            lead <= 1'b0;
                            mag  <= gen_rest;
                        end else begin
                            k <= k - KW'(1);
                        end
                    end
                end
                ST_WR_EMIT: begin
                    if (tx_fire && k != '0) k <= k - KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
Services the SYSCALL instruction for the Sextium III core. It sits between the controller's runio/iobusy handshake and a byte-stream console (rx/tx valid/ready). It implements three operations, selected by the ACC value: HALT, READ (parse a decimal number) and WRITE (print DR as decimal). The result is presented on io_out, which feeds the SELACC_IO input of the ACC mux.

Parameters:
WIDTH, 16, datapath word width (ACC/DR); legal range 8..32
DIGITS, 5, max decimal digits of a WIDTH-bit magnitude; must satisfy 10^(DIGITS-1) < 2^WIDTH <= 10^DIGITS

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
runio  input  1  syscall request from controller, held high until iobusy seen low
code_in  input  WIDTH  syscall number (ACC), sampled at request start
dr_in  input  WIDTH  operand for WRITE (DR), sampled at request start
iobusy  output  1  combinational: runio && state!=FINISH
io_out  output  WIDTH  READ result; stable from FINISH until next READ completes
halted  output  1  sticky HALT indicator
rx_data  input  8  console input byte
rx_valid  input  1  rx byte available
rx_ready  output  1  unit accepts rx byte (transfer when rx_valid&&rx_ready)
tx_data  output  8  console output byte
tx_valid  output  1  tx byte offered; held with tx_data stable until tx_ready
tx_ready  input  1  console accepts tx byte

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; io_out=0, halted=0, rx_ready=0, tx_valid=0, tx_data=0; any in-flight op aborted, partial value discarded, no further bytes emitted.
- States: IDLE, DISPATCH, RD, WR_SIGN, WR_DIG, WR_EMIT, WR_NL, FINISH, HALT.
- IDLE: on runio=1, latch code_in/dr_in -> DISPATCH. iobusy is already high in that same cycle (combinational), as the controller samples it in the cycle after setting runio.
- DISPATCH: code 0 -> HALT; code 1 -> RD (clear accumulator, neg flag, seen_digit); code 2 -> WR_SIGN; any other code -> FINISH, io_out unchanged.
- HALT: halted=1, iobusy held high; the core stalls forever. Only reset exits.
- RD: rx_ready=1. On each accepted byte:
  - '0'..'9': acc = acc*10 + digit, modulo 2^WIDTH (wraps silently).
  - '-' before any digit: set neg.
  - 0x0A: io_out = neg ? -acc : acc (two's complement) -> FINISH.
  - Any other byte: ignored.
  - An empty line yields 0.
  - rx_ready=0 in all other states.
- WR_SIGN: if dr_in is negative, emit '-'. mag = |dr_in| as an unsigned WIDTH-bit value (the most negative value maps to 2^(WIDTH-1)). Then set digit index k=DIGITS-1 and enter WR_DIG.
- WR_DIG: count d by repeated subtraction of 10^k from mag, one subtract per cycle (max 9).
  - Leading zeros are suppressed (lead flag).
  - Digit k=0 is always emitted, so 0 prints "0".
  - Emit '0'+d via WR_EMIT, then decrement k; after k=0 -> WR_NL.
- Emit rule: tx_valid=1 with tx_data fixed; advance only on a cycle where tx_valid&&tx_ready. tx_ready held low stalls indefinitely; iobusy stays high.
- WR_NL: emit 0x0A -> FINISH.
- FINISH: iobusy=0. When runio is observed 0 -> IDLE. If runio is still 1, stay in FINISH; no re-trigger without runio first falling.
- runio falling mid-operation is a protocol violation: the op still completes, then passes through FINISH to IDLE.
- Simultaneous rx and tx activity is not possible: each is used only in its own states.

Decomposition:
- Package sextium_pkg:
  - syscall codes SYS_HALT=0, SYS_READ=1, SYS_WRITE=2
  - ASCII constants CH_0=0x30, CH_MINUS=0x2D, CH_NL=0x0A
  - state encoding
  - power-of-ten constant function/table up to 10^9
- One natural sub-module, dec_digit_gen: the sequential repeated-subtraction digit extractor. Interface: start, mag, k, digit, done.

Test Plan:
- WRITE: runio=1, code=2, dr=1234, tx_ready=1 -> tx bytes 0x31,0x32,0x33,0x34,0x0A; iobusy falls only after the 0x0A transfer; io_out unchanged.
- WRITE edge values: dr=0 -> "0\n"; dr=-32768 (0x8000) -> "-32768\n"; dr=-7 -> "-7\n". Also tx_ready toggled 1-of-3 cycles -> tx_data stable while tx_valid is high and not accepted, identical byte sequence.
- READ: rx stream "-42\n" with rx_valid pulsed sparsely -> io_out=0xFFD6, iobusy low in FINISH. Also "70000\n" -> io_out=0x1170 (wrap). Also "\n" -> io_out=0. Also "a1b2\n" -> io_out=12.
- HALT and unknown codes: code=0 -> halted=1 and iobusy stays 1 for 100 cycles, with tx_valid=0 and rx_ready=0. Code=7 -> iobusy falls 2 cycles after runio rises, with io_out unchanged.
- Handshake: runio held high 5 cycles past FINISH -> stays in FINISH, no second op; runio low -> IDLE next cycle. A new request right after works.
- Reset mid-WRITE after 2 digits: tx_valid=0 and all outputs at reset values on the next cycle; a subsequent WRITE of 5 prints "5\n" cleanly.
